// File: rtl/ccip_tx_rr_sched_if.sv
// Bundle of request, response and grant signals between the sub-AFU side
// (master) and the round-robin Tx scheduler (slave).
interface ccip_tx_rr_sched_if #(
  parameter int NUM_SUB_AFUS = 8,
  parameter int IDX_W        = $clog2(NUM_SUB_AFUS)
);
  logic [NUM_SUB_AFUS-1:0] req_valid;
  logic                    up_almFull;
  logic                    rsp_valid;
  logic [IDX_W-1:0]        rsp_idx;
  logic                    grant_valid;
  logic [IDX_W-1:0]        grant_idx;
  logic [NUM_SUB_AFUS-1:0] grant_onehot;
  logic [NUM_SUB_AFUS-1:0] credit_exhausted;
  logic                    rsp_underflow;
  logic [31:0]             stat_grants;

  modport master (
    output req_valid, up_almFull, rsp_valid, rsp_idx,
    input  grant_valid, grant_idx, grant_onehot, credit_exhausted,
           rsp_underflow, stat_grants
  );

  modport slave (
    input  req_valid, up_almFull, rsp_valid, rsp_idx,
    output grant_valid, grant_idx, grant_onehot, credit_exhausted,
           rsp_underflow, stat_grants
  );
endinterface

// File: rtl/ccip_tx_rr_sched.sv
// Round-robin Tx grant scheduler with per-requester outstanding-credit limits.
// Optional grant counter enabled by macro CCIP_TX_SCHED_STATS_EN.
module ccip_tx_rr_sched #(
  parameter int NUM_SUB_AFUS    = 8,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                   pClk,
  input  logic                   SoftReset,
  ccip_tx_rr_sched_if.slave      bus
);
  localparam int IDX_W = $clog2(NUM_SUB_AFUS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]        cnt_q [NUM_SUB_AFUS];
  logic [CNT_W-1:0]        cnt_d [NUM_SUB_AFUS];
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic                    grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
  logic [NUM_SUB_AFUS-1:0] grant_onehot_q, grant_onehot_d;
  logic [NUM_SUB_AFUS-1:0] credit_exh_q, credit_exh_d;
  logic                    rsp_underflow_q, rsp_underflow_d;

  logic [NUM_SUB_AFUS-1:0] elig_s;
  logic [IDX_W-1:0]        cand_s [NUM_SUB_AFUS];
  logic                    win_found_s;
  logic [IDX_W-1:0]        win_idx_s;
  logic                    grant_fire_s;
  logic [NUM_SUB_AFUS-1:0] inc_s, hit_s;
  logic                    rsp_bad_s;

  // Eligibility and the rotated search order starting just past the last winner.
  always_comb begin
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      elig_s[i] = bus.req_valid[i] && (cnt_q[i] < CNT_MAX);
      cand_s[i] = IDX_W'((int'(ptr_q) + i) % NUM_SUB_AFUS);
    end
  end

  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = ptr_q;
    for (int k = 0; k < NUM_SUB_AFUS; k++) begin
      if (!win_found_s && elig_s[cand_s[k]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[k];
      end else begin
        win_found_s = win_found_s;
      end
    end
    grant_fire_s = win_found_s && !bus.up_almFull;
  end

  // Credit accounting; a grant and a response on the same index cancel out.
  always_comb begin
    rsp_bad_s = bus.rsp_valid && (int'(bus.rsp_idx) >= NUM_SUB_AFUS);
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      inc_s[i] = grant_fire_s && (win_idx_s == IDX_W'(i));
      hit_s[i] = bus.rsp_valid && (bus.rsp_idx == IDX_W'(i));
      if (hit_s[i] && (cnt_q[i] == '0)) begin
        rsp_bad_s = 1'b1;
      end else begin
        rsp_bad_s = rsp_bad_s;
      end
      case ({inc_s[i], hit_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = (cnt_q[i] == '0) ? cnt_q[i] : cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      credit_exh_d[i] = (cnt_d[i] == CNT_MAX);
    end
    rsp_underflow_d = rsp_underflow_q || rsp_bad_s;
  end

  always_comb begin
    grant_valid_d = grant_fire_s;
    if (grant_fire_s) begin
      grant_idx_d    = win_idx_s;
      grant_onehot_d = NUM_SUB_AFUS'(1) << win_idx_s;
      ptr_d          = IDX_W'((int'(win_idx_s) + 1) % NUM_SUB_AFUS);
    end else begin
      grant_idx_d    = grant_idx_q;
      grant_onehot_d = '0;
      ptr_d          = ptr_q;
    end
  end

  // Scheduler state register with synchronous reset.
  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      for (int i = 0; i < NUM_SUB_AFUS; i++) cnt_q[i] <= '0;
      ptr_q           <= '0;
      grant_valid_q   <= 1'b0;
      grant_idx_q     <= '0;
      grant_onehot_q  <= '0;
      credit_exh_q    <= '0;
      rsp_underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SUB_AFUS; i++) cnt_q[i] <= cnt_d[i];
      ptr_q           <= ptr_d;
      grant_valid_q   <= grant_valid_d;
      grant_idx_q     <= grant_idx_d;
      grant_onehot_q  <= grant_onehot_d;
      credit_exh_q    <= credit_exh_d;
      rsp_underflow_q <= rsp_underflow_d;
    end
  end

  assign bus.grant_valid      = grant_valid_q;
  assign bus.grant_idx        = grant_idx_q;
  assign bus.grant_onehot     = grant_onehot_q;
  assign bus.credit_exhausted = credit_exh_q;
  assign bus.rsp_underflow    = rsp_underflow_q;

`ifdef CCIP_TX_SCHED_STATS_EN
  logic [31:0] stat_grants_q;

  // Free-running grant counter, wraps naturally at 32 bits.
  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      stat_grants_q <= 32'd0;
    end else if (grant_fire_s) begin
      stat_grants_q <= stat_grants_q + 32'd1;
    end else begin
      stat_grants_q <= stat_grants_q;
    end
  end

  assign bus.stat_grants = stat_grants_q;
`else
  assign bus.stat_grants = 32'd0;
`endif

endmodule
